// File: rtl/align_pkg.sv
// Shared types and widths for the FP16 partial-product alignment sequencer.
// Fixed field widths are tied to the alignment datapath beside the controller.
package align_pkg;

  localparam int EXP_W = 5;
  localparam int PP_W  = 5;
  localparam int ALN_W = 16;

  typedef struct packed {
    logic [EXP_W-1:0] exp;
    logic [PP_W-1:0]  pp;
  } pp_entry_t;

  typedef enum logic {
    LOAD  = 1'b0,
    ALIGN = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/max_exp_tracker.sv
// Registered running maximum of the exponents in the group being loaded.
// The first product of a group loads directly, so a previous group's max never leaks in.
module max_exp_tracker
  import align_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic             i_first,
  input  logic [EXP_W-1:0] i_exp,
  output logic [EXP_W-1:0] o_expMax
);

  logic [EXP_W-1:0] r_expMax;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_expMax <= '0;
    end else if (i_clear) begin
      r_expMax <= '0;
    end else if (i_load) begin
      if (i_first || (i_exp > r_expMax)) begin
        r_expMax <= i_exp;
      end
    end
  end

  assign o_expMax = r_expMax;

endmodule

// File: rtl/align_group_ctrl.sv
// Two-pass sequencer: LOAD buffers a group of products and tracks their max exponent,
// ALIGN replays them through the external alignment unit and streams the results.
module align_group_ctrl
  import align_pkg::*;
#(
  parameter int GROUP_N = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [PP_W-1:0]  in_pp,
  output logic [EXP_W-1:0] align_exp,
  output logic [EXP_W-1:0] align_exp_max,
  output logic [PP_W-1:0]  align_pp,
  input  logic [ALN_W-1:0] aligned_pp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ALN_W-1:0] out_data,
  output logic             out_last,
  output logic [EXP_W-1:0] group_exp_max
);

  localparam int CNT_W = $clog2(GROUP_N);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(GROUP_N - 1);

  ctrl_state_t      r_state;
  ctrl_state_t      w_nextState;
  logic [CNT_W-1:0] r_wrCnt;
  logic [CNT_W-1:0] r_rdCnt;
  pp_entry_t        r_buf [GROUP_N];
  logic             w_inFire;
  logic             w_outFire;
  logic             w_wrLast;
  logic             w_rdLast;
  logic [EXP_W-1:0] w_expMax;

  assign w_wrLast = (r_wrCnt == LAST_IDX);
  assign w_rdLast = (r_rdCnt == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Handshakes coinciding with clear are discarded, so clear masks both fire strobes.
  always_comb begin
    w_nextState   = r_state;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    out_last      = 1'b0;
    out_data      = '0;
    align_exp     = '0;
    align_exp_max = '0;
    align_pp      = '0;
    w_inFire      = 1'b0;
    w_outFire     = 1'b0;
    case (r_state)
      LOAD: begin
        in_ready = 1'b1;
        w_inFire = in_valid && !clear;
        if (w_inFire && w_wrLast) begin
          w_nextState = ALIGN;
        end
      end
      ALIGN: begin
        out_valid     = 1'b1;
        align_exp     = r_buf[r_rdCnt].exp;
        align_pp      = r_buf[r_rdCnt].pp;
        align_exp_max = w_expMax;
        out_data      = aligned_pp;
        out_last      = w_rdLast;
        w_outFire     = out_ready && !clear;
        if (w_outFire && w_rdLast) begin
          w_nextState = LOAD;
        end
      end
      default: w_nextState = LOAD;
    endcase
    if (clear) begin
      w_nextState = LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrCnt <= '0;
      r_rdCnt <= '0;
    end else if (clear) begin
      r_wrCnt <= '0;
      r_rdCnt <= '0;
    end else begin
      if (w_inFire) begin
        r_wrCnt <= w_wrLast ? '0 : r_wrCnt + 1'b1;
      end
      if (w_outFire) begin
        r_rdCnt <= w_rdLast ? '0 : r_rdCnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < GROUP_N; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_inFire) begin
      r_buf[r_wrCnt] <= '{exp: in_exp, pp: in_pp};
    end
  end

  max_exp_tracker u_maxExp (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (clear),
    .i_load   (w_inFire),
    .i_first  (r_wrCnt == '0),
    .i_exp    (in_exp),
    .o_expMax (w_expMax)
  );

  assign group_exp_max = w_expMax;

endmodule

// File: tb/tb_align_group_ctrl.sv
// Randomized and directed bench for align_group_ctrl with GROUP_N = 4 and a behavioural
// alignment unit attached; expectations come from the stored group and its computed max.
module tb_align_group_ctrl;
  import align_pkg::*;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [EXP_W-1:0] in_exp;
  logic [PP_W-1:0]  in_pp;
  logic [EXP_W-1:0] align_exp;
  logic [EXP_W-1:0] align_exp_max;
  logic [PP_W-1:0]  align_pp;
  logic [ALN_W-1:0] aligned_pp;
  logic             out_valid;
  logic             out_ready;
  logic [ALN_W-1:0] out_data;
  logic             out_last;
  logic [EXP_W-1:0] group_exp_max;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [EXP_W-1:0] gExp [N];
  logic [PP_W-1:0]  gPp  [N];

  always #5 clk = ~clk;

  align_group_ctrl #(.GROUP_N(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_exp        (in_exp),
    .in_pp         (in_pp),
    .align_exp     (align_exp),
    .align_exp_max (align_exp_max),
    .align_pp      (align_pp),
    .aligned_pp    (aligned_pp),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .group_exp_max (group_exp_max)
  );

  // Stand-in alignment unit: sign-extend, scale up, then shift right by the exponent gap.
  function automatic logic [ALN_W-1:0] alignModel(input logic [EXP_W-1:0] e,
                                                  input logic [PP_W-1:0] p,
                                                  input logic [EXP_W-1:0] m);
    logic signed [ALN_W-1:0] ext;
    ext = {{(ALN_W-PP_W){p[PP_W-1]}}, p};
    ext = ext <<< 10;
    return ext >>> (m - e);
  endfunction

  assign aligned_pp = alignModel(align_exp, align_pp, align_exp_max);

  function automatic logic [EXP_W-1:0] groupMax();
    int m = 0;
    for (int i = 0; i < N; i++) begin
      if (int'(gExp[i]) > m) m = int'(gExp[i]);
    end
    return EXP_W'(m);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    testsRun++;
    assert (obs === expv) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic randGroup(input int maxExp);
    for (int i = 0; i < N; i++) begin
      gExp[i] = EXP_W'($urandom_range(0, maxExp));
      gPp[i]  = PP_W'($urandom);
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_exp   = gExp[i];
      in_pp    = gPp[i];
      @(negedge clk);
      checkOutput("in_ready_load", 32'(in_ready), 32'd1);
      checkOutput("out_valid_load", 32'(out_valid), 32'd0);
      stepCycle();
    end
    in_valid = 1'b0;
    checkOutput("group_exp_max", 32'(group_exp_max), 32'(groupMax()));
    checkOutput("first_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic checkBeat(input int k);
    logic [EXP_W-1:0] m;
    m = groupMax();
    checkOutput("out_valid", 32'(out_valid), 32'd1);
    checkOutput("in_ready_align", 32'(in_ready), 32'd0);
    checkOutput("align_exp", 32'(align_exp), 32'(gExp[k]));
    checkOutput("align_pp", 32'(align_pp), 32'(gPp[k]));
    checkOutput("align_exp_max", 32'(align_exp_max), 32'(m));
    checkOutput("out_data", 32'(out_data), 32'(alignModel(gExp[k], gPp[k], m)));
    checkOutput("out_last", 32'(out_last), 32'(k == N-1));
  endtask

  // Emits beats 0..stopAt-1; with stopAt < N it returns while beat stopAt is presented.
  task automatic drainGroup(input int stallAt, input int stallCycles, input int stopAt);
    for (int k = 0; k < N; k++) begin
      if (k == stopAt) return;
      if (k == stallAt) begin
        out_ready = 1'b0;
        for (int s = 0; s < stallCycles; s++) begin
          @(negedge clk);
          checkBeat(k);
          stepCycle();
        end
      end
      out_ready = 1'b1;
      @(negedge clk);
      checkBeat(k);
      stepCycle();
    end
    out_ready = 1'b0;
    checkOutput("post_out_valid", 32'(out_valid), 32'd0);
    checkOutput("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic basicGroup();
    gExp[0] = 5'd2; gExp[1] = 5'd5; gExp[2] = 5'd4; gExp[3] = 5'd1;
    gPp[0] = 5'b11010; gPp[1] = 5'b00111; gPp[2] = 5'b00001; gPp[3] = 5'b10000;
    applyStimulus();
    checkOutput("basic_max", 32'(group_exp_max), 32'd5);
    drainGroup(-1, 0, N);
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_exp    = '0;
    in_pp     = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
    checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
    checkOutput("idle_group_exp_max", 32'(group_exp_max), 32'd0);
    checkOutput("idle_align_exp", 32'(align_exp), 32'd0);
    checkOutput("idle_align_exp_max", 32'(align_exp_max), 32'd0);
    checkOutput("idle_align_pp", 32'(align_pp), 32'd0);
    checkOutput("idle_out_data", 32'(out_data), 32'd0);
    checkOutput("idle_out_last", 32'(out_last), 32'd0);
    stepCycle();

    basicGroup();

    // Stale-max isolation: a high-max group followed by an all-3 group.
    randGroup(10);
    gExp[$urandom_range(0, N-1)] = 5'd10;
    applyStimulus();
    drainGroup(-1, 0, N);
    randGroup(0);
    for (int i = 0; i < N; i++) gExp[i] = 5'd3;
    applyStimulus();
    checkOutput("stale_max", 32'(group_exp_max), 32'd3);
    drainGroup(-1, 0, N);

    randGroup(31);
    applyStimulus();
    drainGroup(1, 5, N);

    // Clear during LOAD with a product offered in the same cycle.
    randGroup(20);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_exp   = gExp[i];
      in_pp    = gPp[i];
      stepCycle();
    end
    in_exp = 5'd31;
    in_pp  = 5'b01111;
    clear  = 1'b1;
    stepCycle();
    clear    = 1'b0;
    in_valid = 1'b0;
    checkOutput("clr_load_max", 32'(group_exp_max), 32'd0);
    checkOutput("clr_load_in_ready", 32'(in_ready), 32'd1);
    checkOutput("clr_load_out_valid", 32'(out_valid), 32'd0);
    randGroup(20);
    applyStimulus();
    drainGroup(-1, 0, N);

    // Clear during ALIGN at beat 2.
    randGroup(31);
    applyStimulus();
    drainGroup(-1, 0, 2);
    out_ready = 1'b1;
    clear     = 1'b1;
    stepCycle();
    clear     = 1'b0;
    out_ready = 1'b0;
    checkOutput("clr_align_out_valid", 32'(out_valid), 32'd0);
    checkOutput("clr_align_in_ready", 32'(in_ready), 32'd1);
    checkOutput("clr_align_max", 32'(group_exp_max), 32'd0);
    randGroup(31);
    applyStimulus();
    drainGroup(-1, 0, N);

    // Asynchronous reset between clock edges while the last beat is presented.
    randGroup(31);
    applyStimulus();
    drainGroup(-1, 0, N-1);
    checkOutput("pre_rst_out_last", 32'(out_last), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_last", 32'(out_last), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_max", 32'(group_exp_max), 32'd0);
    out_ready = 1'b0;
    stepCycle();
    rst_n = 1'b1;
    stepCycle();
    basicGroup();

    for (int g = 0; g < 6; g++) begin
      randGroup(31);
      applyStimulus();
      drainGroup($urandom_range(0, N-1), $urandom_range(0, 3), N);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/align_group_ctrl.md
Name: align_group_ctrl

Overview:
- Sequencer for the FP16 partial-product alignment datapath (`alignment`: exp, exp_max, signed_pp -> aligned_pp) in the MAC path.
- Pass 1 (LOAD): collects a group of GROUP_N partial products (exponent plus signed mantissa product) and tracks the group's maximum exponent.
- Pass 2 (ALIGN): replays the stored products through `alignment` with the group exp_max and streams the 16-bit aligned results to the adder tree over valid/ready.
- `alignment` is instantiated beside this block, not inside it.

Parameters:
- GROUP_N, 9, products per group (3x3 kernel); must be >= 2.
- EXP_W, 5, exponent width.
- PP_W, 5, signed partial-product width.
- ALN_W, 16, aligned output width.
- CNT_W, $clog2(GROUP_N), counter width (derived; not overridden).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort; discards the current group.
- in_valid  in  1  input product valid.
- in_ready  out  1  block can accept a product.
- in_exp  in  EXP_W  product exponent.
- in_pp  in  PP_W  signed partial product.
- align_exp  out  EXP_W  to alignment.exp.
- align_exp_max  out  EXP_W  to alignment.exp_max.
- align_pp  out  PP_W  to alignment.signed_pp.
- aligned_pp  in  ALN_W  from alignment.aligned_pp (combinational return).
- out_valid  out  1  aligned result valid.
- out_ready  in  1  downstream accepts.
- out_data  out  ALN_W  aligned result.
- out_last  out  1  final result of the group.
- group_exp_max  out  EXP_W  registered max exponent of the current/last group.

Behaviour:
- One clock; reset is asynchronous and active-low. rst_n low forces the following regardless of clk:
  - state = LOAD; wr_cnt = 0; rd_cnt = 0; exp_max_r = 0; buffer contents = 0.
  - out_valid = 0; out_last = 0; align_* = 0; out_data = 0; group_exp_max = 0; in_ready = 1.
- States: LOAD and ALIGN only.
- LOAD:
  - in_ready = 1; out_valid = 0; align_* driven 0.
  - Accept on in_valid & in_ready: buf[wr_cnt] <= {in_exp, in_pp}; wr_cnt++.
  - exp_max_r <= in_exp when wr_cnt == 0 (the first element never compares against the previous group). Otherwise exp_max_r <= max(exp_max_r, in_exp), unsigned compare.
  - An accept with wr_cnt == GROUP_N-1 moves to ALIGN next cycle: wr_cnt <= 0, rd_cnt <= 0. The last element's exponent is included in exp_max_r before ALIGN begins.
- ALIGN:
  - in_ready = 0; out_valid = 1.
  - align_exp = buf[rd_cnt].exp; align_pp = buf[rd_cnt].pp; align_exp_max = exp_max_r.
  - out_data = aligned_pp, combinational passthrough; zero added latency.
  - out_last = (rd_cnt == GROUP_N-1).
  - On out_valid & out_ready: rd_cnt++. If out_last, go to LOAD next cycle.
  - While out_ready = 0, all align_* and out_* hold stable (AXI-style: valid never drops without a handshake).
- group_exp_max = exp_max_r at all times. It holds the last group's value until the next group's first accept.
- Timing: load and emit do not overlap. The minimum group period is 2*GROUP_N cycles. The first out_valid is the cycle after the last input accept.
- clear (synchronous, highest priority after reset):
  - Next state LOAD; wr_cnt = rd_cnt = 0; exp_max_r = 0.
  - An input handshake or output handshake in the same cycle is discarded: the data is not stored and the output is not counted.
  - Downstream must ignore the result if out_ready coincided with clear.
- Exponent equality: exp == exp_max is legal (zero shift). Exponent 0 (subnormal/zero) is treated as an ordinary value.
- Reset mid-group: all state is lost; there is no partial output.

Decomposition:
- Package align_pkg holds:
  - localparams EXP_W = 5, PP_W = 5, ALN_W = 16.
  - typedef pp_entry_t = struct {exp, pp}.
  - enum ctrl_state_t {LOAD, ALIGN}.
- Sub-module max_exp_tracker (registered running max with first-element load and clear) is the natural split. The buffer and counters stay in the top module.

Test Plan:
- Reset and idle: hold rst_n = 0 for 3 cycles, then release -> in_ready = 1, out_valid = 0, group_exp_max = 0, align_* = 0.
- Basic group (GROUP_N = 4, real `alignment` attached):
  - Inputs exp = {2, 5, 4, 1}, pp = {11010, 00111, 00001, 10000}, with out_ready = 1.
  - Expect group_exp_max = 5 after the 4th accept.
  - Expect 4 outputs on consecutive cycles with align_exp = 2, 5, 4, 1, align_exp_max = 5, out_data equal to aligned_pp each cycle, and out_last only on the 4th.
- Stale-max isolation: group A with max exp 10, then group B with all exp = 3 -> group B drives align_exp_max = 3 on every output.
- Backpressure: hold out_ready = 0 for 5 cycles at rd_cnt = 1 -> align_exp, align_pp, out_data, out_last are unchanged; in_ready = 0; after release the remaining outputs emit in order with no loss or duplication.
- Clear mid-load and mid-align:
  - After 2 accepts, assert clear together with in_valid -> next cycle wr_cnt = 0 and the dropped product never appears.
  - Assert clear at rd_cnt = 2 in ALIGN -> next cycle in_ready = 1, out_valid = 0.
- Async reset mid-ALIGN: pull rst_n low between clock edges -> out_valid and out_last fall immediately; after release the next group behaves as in the basic-group scenario.
